// File: rtl/fm_audio_i2s_tx.sv
// I2S transmitter for the fmsynth stereo output. Applies a Q1.7 volume gain
// with saturation and mute, then serializes 16-bit left/right words MSB first.
module fm_audio_i2s_tx #(
  parameter int BCLK_DIV = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] audio_l,
  input  logic [15:0] audio_r,
  input  logic [7:0]  volume,
  input  logic        mute,
  output logic        sample_strobe,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_data
);

  localparam int DW = $clog2(BCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

  // Signed sample times unsigned gain; the magnitude always fits in 25 bits.
  function automatic logic signed [24:0] gain_mul(input logic [15:0] s, input logic [7:0] v);
    logic signed [24:0] a;
    logic signed [24:0] b;
    a = {{9{s[15]}}, s};
    b = {17'd0, v};
    return a * b;
  endfunction

  function automatic logic [15:0] shift_sat(input logic signed [24:0] p, input logic m);
    logic signed [24:0] q;
    q = p >>> 7;
    if (m) begin
      return 16'h0000;
    end else if (q > 25'sd32767) begin
      return 16'h7FFF;
    end else if (q < -25'sd32768) begin
      return 16'h8000;
    end else begin
      return q[15:0];
    end
  endfunction

  logic [DW-1:0]      divcnt_q, divcnt_d;
  logic [4:0]         bitcnt_q, bitcnt_d;
  logic               bclk_q, bclk_d;
  logic               lrclk_q, lrclk_d;
  logic               data_q, data_d;
  logic               strobe_q;
  logic [15:0]        l_tx_q, l_tx_d;
  logic [15:0]        r_tx_q, r_tx_d;
  logic [15:0]        cap_l_q, cap_r_q;
  logic [7:0]         cap_vol_q;
  logic               cap_mute_q;
  logic signed [24:0] prod_l_q, prod_r_q;
  logic [15:0]        gain_l_q, gain_r_q;
  logic               tick_s, fall_s, load_s, cap_s;

  // Next-state logic for the divider, bit counter and serializer.
  always_comb begin
    tick_s   = (divcnt_q == DIV_LAST);
    fall_s   = tick_s & bclk_q;
    divcnt_d = tick_s ? {DW{1'b0}} : divcnt_q + DW'(1);
    bclk_d   = tick_s ? ~bclk_q : bclk_q;
    bitcnt_d = fall_s ? bitcnt_q + 5'd1 : bitcnt_q;
    load_s   = fall_s && (bitcnt_d == 5'd0);
    cap_s    = fall_s && (bitcnt_d == 5'd30);
    l_tx_d   = load_s ? gain_l_q : l_tx_q;
    r_tx_d   = load_s ? gain_r_q : r_tx_q;
    // The word loaded at bitcnt 0 must already drive its MSB in that cycle.
    if (fall_s) begin
      lrclk_d = (bitcnt_d >= 5'd15) && (bitcnt_d <= 5'd30);
      if (bitcnt_d[4] == 1'b0) begin
        data_d = l_tx_d[4'd15 - bitcnt_d[3:0]];
      end else begin
        data_d = r_tx_d[4'd15 - bitcnt_d[3:0]];
      end
    end else begin
      lrclk_d = lrclk_q;
      data_d  = data_q;
    end
  end

  // State registers, capture stage and the two-cycle gain pipeline.
  always_ff @(posedge clk) begin
    if (!reset) begin
      divcnt_q   <= {DW{1'b0}};
      bitcnt_q   <= 5'd31;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      data_q     <= 1'b0;
      strobe_q   <= 1'b0;
      l_tx_q     <= 16'h0000;
      r_tx_q     <= 16'h0000;
      cap_l_q    <= 16'h0000;
      cap_r_q    <= 16'h0000;
      cap_vol_q  <= 8'h00;
      cap_mute_q <= 1'b0;
      prod_l_q   <= 25'sd0;
      prod_r_q   <= 25'sd0;
      gain_l_q   <= 16'h0000;
      gain_r_q   <= 16'h0000;
    end else begin
      divcnt_q <= divcnt_d;
      bitcnt_q <= bitcnt_d;
      bclk_q   <= bclk_d;
      lrclk_q  <= lrclk_d;
      data_q   <= data_d;
      strobe_q <= cap_s;
      l_tx_q   <= l_tx_d;
      r_tx_q   <= r_tx_d;
      if (cap_s) begin
        cap_l_q    <= audio_l;
        cap_r_q    <= audio_r;
        cap_vol_q  <= volume;
        cap_mute_q <= mute;
      end else begin
        cap_l_q    <= cap_l_q;
        cap_r_q    <= cap_r_q;
        cap_vol_q  <= cap_vol_q;
        cap_mute_q <= cap_mute_q;
      end
      prod_l_q <= gain_mul(cap_l_q, cap_vol_q);
      prod_r_q <= gain_mul(cap_r_q, cap_vol_q);
      gain_l_q <= shift_sat(prod_l_q, cap_mute_q);
      gain_r_q <= shift_sat(prod_r_q, cap_mute_q);
    end
  end

  assign sample_strobe = strobe_q;
  assign i2s_bclk      = bclk_q;
  assign i2s_lrclk     = lrclk_q;
  assign i2s_data      = data_q;

endmodule

// File: tb/tb_fm_audio_i2s_tx.sv
// Directed bench for fm_audio_i2s_tx: cadence, gain/saturation vectors,
// mute timing and mid-frame reset, deserializing the I2S stream.
module tb_fm_audio_i2s_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] audio_l, audio_r;
  logic [7:0]  volume;
  logic        mute;
  logic        sample_strobe, i2s_bclk, i2s_lrclk, i2s_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  vol;
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  fm_audio_i2s_tx #(.BCLK_DIV(8)) dut (
    .clk(clk), .reset(reset), .audio_l(audio_l), .audio_r(audio_r),
    .volume(volume), .mute(mute), .sample_strobe(sample_strobe),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_data(i2s_data)
  );

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe();
    bit seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (sample_strobe) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL strobe_timeout: actual none required pulse within 600 cycles");
    end
  endtask

  // Entered on a fall cycle at bitcnt 31; leaves at bitcnt 31 of the collected frame.
  task automatic collect(input bit scramble, output logic [15:0] l, output logic [15:0] r,
                         output int lr_bad);
    logic exp_lr;
    l = 16'h0000;
    r = 16'h0000;
    lr_bad = 0;
    for (int k = 0; k < 32; k++) begin
      repeat (16) step();
      if (k < 16) l[15-k] = i2s_data;
      else        r[31-k] = i2s_data;
      exp_lr = (k >= 15) && (k <= 30);
      if (i2s_lrclk !== exp_lr) lr_bad++;
      if (scramble && k == 5) begin
        audio_l = 16'h5A5A;
        audio_r = 16'hA5A5;
        volume  = 8'd200;
        mute    = 1'b1;
      end
    end
  endtask

  // Called right after reset is released; observes 1100 cycles.
  task automatic cadence(input string tag);
    int first_rise = -1, second_rise = -1, s0 = -1, s1 = -1, ns = 0, nz = 0, bad = 0;
    logic pb = 1'b0, plr = 1'b0, pd = 1'b0;
    for (int c = 1; c <= 1100; c++) begin
      step();
      if (i2s_bclk && !pb) begin
        if (first_rise < 0) first_rise = c;
        else if (second_rise < 0) second_rise = c;
      end
      if (sample_strobe) begin
        ns++;
        if (s0 < 0) s0 = c;
        else if (s1 < 0) s1 = c;
      end
      if (c < 528 && i2s_data) nz++;
      if ((i2s_lrclk != plr || i2s_data != pd) && !(pb && !i2s_bclk)) bad++;
      pb = i2s_bclk; plr = i2s_lrclk; pd = i2s_data;
    end
    chk({tag, "_first_rise"}, first_rise, 8);
    chk({tag, "_bclk_period"}, second_rise - first_rise, 16);
    chk({tag, "_strobe_count"}, ns, 2);
    chk({tag, "_first_strobe"}, s0, 496);
    chk({tag, "_strobe_spacing"}, s1 - s0, 512);
    chk({tag, "_frame0_nonzero_bits"}, nz, 0);
    chk({tag, "_change_off_fall"}, bad, 0);
  endtask

  initial begin
    logic [15:0] got_l, got_r;
    int lr_bad;

    vecs[0] = '{8'd128, 16'h1234, 16'h8001, 16'h1234, 16'h8001};
    vecs[1] = '{8'd255, 16'h7000, 16'h9000, 16'h7FFF, 16'h8000};
    vecs[2] = '{8'd64,  16'h4000, 16'hFFFF, 16'h2000, 16'hFFFF};
    vecs[3] = '{8'd0,   16'h7FFF, 16'h8000, 16'h0000, 16'h0000};
    vecs[4] = '{8'd200, 16'h0100, 16'hFF00, 16'h0190, 16'hFE70};
    vecs[5] = '{8'd255, 16'h0001, 16'hFFFF, 16'h0001, 16'hFFFE};

    reset = 1'b0; audio_l = 16'h1111; audio_r = 16'h2222; volume = 8'd128; mute = 1'b0;
    repeat (4) step();
    chk("reset_outputs", {28'd0, i2s_bclk, i2s_lrclk, i2s_data, sample_strobe}, 0);
    reset = 1'b1;
    cadence("por");

    for (int i = 0; i < 6; i++) begin
      wait_strobe();
      volume = vecs[i].vol; audio_l = vecs[i].l; audio_r = vecs[i].r; mute = 1'b0;
      wait_strobe();
      repeat (16) step();
      collect(1'b1, got_l, got_r, lr_bad);
      chk($sformatf("vec%0d_left", i), int'(got_l), int'(vecs[i].exp_l));
      chk($sformatf("vec%0d_right", i), int'(got_r), int'(vecs[i].exp_r));
      chk($sformatf("vec%0d_lrclk", i), lr_bad, 0);
    end

    // Mute raised just after a capture must only silence the frame after next.
    wait_strobe();
    volume = 8'd128; audio_l = 16'h1234; audio_r = 16'h8001; mute = 1'b0;
    wait_strobe();
    mute = 1'b1;
    repeat (16) step();
    collect(1'b0, got_l, got_r, lr_bad);
    chk("mute_pre_left", int'(got_l), 32'h1234);
    chk("mute_pre_right", int'(got_r), 32'h8001);
    collect(1'b0, got_l, got_r, lr_bad);
    chk("mute_left", int'(got_l), 0);
    chk("mute_right", int'(got_r), 0);
    chk("mute_lrclk", lr_bad, 0);
    mute = 1'b0;

    // Reset at bitcnt 20 (22 falls after the strobe at bitcnt 30).
    wait_strobe();
    wait_strobe();
    repeat (352) step();
    reset = 1'b0;
    step();
    chk("midreset_outputs", {28'd0, i2s_bclk, i2s_lrclk, i2s_data, sample_strobe}, 0);
    repeat (2) step();
    reset = 1'b1;
    cadence("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
